// File: rtl/rmio_seq_ctrl.sv
// rmio_seq_ctrl: RF-RAM to EU operand load / result drain sequencer; define RMIO_SEQ_PIPE_RD_EN for pipelined operand reads
module rmio_seq_ctrl #(
  parameter int INPUT_NUM  = 2,
  parameter int OUTPUT_NUM = 1,
  parameter int DATA_W     = 1408,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [INPUT_NUM*ADDR_W-1:0]    src_addr,
  input  logic [OUTPUT_NUM*ADDR_W-1:0]   dst_addr,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic                           ram_re,
  output logic                           ram_we,
  input  logic [DATA_W-1:0]              ram_rdata,
  output logic [DATA_W-1:0]              ram_wdata,
  output logic [DATA_W-1:0]              input_data,
  output logic [INPUT_NUM-1:0]           input_we,
  input  logic [DATA_W-1:0]              output_data,
  output logic [OUTPUT_NUM-1:0]          output_re,
  output logic                           eu_start,
  input  logic                           eu_done
);
  localparam int IW = INPUT_NUM > 1 ? $clog2(INPUT_NUM) : 1;
  localparam int JW = OUTPUT_NUM > 1 ? $clog2(OUTPUT_NUM) : 1;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, LOAD, EXEC, EXEC_WAIT, WR, DONE} state_t;
  state_t state;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [INPUT_NUM*ADDR_W-1:0] src_q;
  logic [OUTPUT_NUM*ADDR_W-1:0] dst_q;
  logic last_i;
  assign last_i = i == IW'(INPUT_NUM - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign eu_start = state == EXEC;
  assign ram_re = state == RD_ISSUE;
  assign ram_we = state == WR;
  assign output_re = ram_we ? OUTPUT_NUM'(1) << j : '0;
  assign ram_addr = ram_re ? src_q[i*ADDR_W +: ADDR_W] : ram_we ? dst_q[j*ADDR_W +: ADDR_W] : '0;
  assign input_data = ram_rdata;
  assign ram_wdata = output_data;
`ifdef RMIO_SEQ_PIPE_RD_EN
  // each issued read carries its one-hot operand strobe down a RD_LAT-deep delay line
  logic [INPUT_NUM-1:0] rd_pipe [RD_LAT];
  assign input_we = rd_pipe[RD_LAT-1];
`else
  localparam int CW = $clog2(RD_LAT + 1);
  logic [CW-1:0] cnt;
  assign input_we = state == LOAD ? INPUT_NUM'(1) << i : '0;
`endif
  // sequencer state, indices and latched addresses; abort beats every transition outside IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      src_q <= '0;
      dst_q <= '0;
`ifdef RMIO_SEQ_PIPE_RD_EN
      for (int k = 0; k < RD_LAT; k++) rd_pipe[k] <= '0;
`else
      cnt <= '0;
`endif
    end else if (abort && state != IDLE) begin
      state <= IDLE;
`ifdef RMIO_SEQ_PIPE_RD_EN
      for (int k = 0; k < RD_LAT; k++) rd_pipe[k] <= '0;
`endif
    end else begin
`ifdef RMIO_SEQ_PIPE_RD_EN
      rd_pipe[0] <= state == RD_ISSUE ? INPUT_NUM'(1) << i : '0;
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
`endif
      case (state)
        IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          i <= '0;
          state <= RD_ISSUE;
        end
`ifdef RMIO_SEQ_PIPE_RD_EN
        RD_ISSUE: if (last_i) state <= RD_WAIT; else i <= i + 1'b1;
        RD_WAIT: if (input_we[INPUT_NUM-1]) state <= EXEC;
`else
        RD_ISSUE: begin
          cnt <= '0;
          state <= RD_LAT > 1 ? RD_WAIT : LOAD;
        end
        RD_WAIT: if (cnt == CW'(RD_LAT > 1 ? RD_LAT - 2 : 0)) state <= LOAD; else cnt <= cnt + 1'b1;
`endif
        LOAD: if (last_i) state <= EXEC; else begin
          i <= i + 1'b1;
          state <= RD_ISSUE;
        end
        EXEC: state <= EXEC_WAIT;
        EXEC_WAIT: if (eu_done) begin
          j <= '0;
          state <= WR;
        end
        WR: if (j == JW'(OUTPUT_NUM - 1)) state <= DONE; else j <= j + 1'b1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rmio_seq_ctrl.sv
// tb_rmio_seq_ctrl: schedule-model checker for rmio_seq_ctrl over four parameterisations
module tb_rmio_seq_ctrl;
  localparam int NU = 4;
  localparam int NC = 400;
  localparam int BIG = 1 << 30;

  typedef struct packed {
    bit re, we, es, dn, bz;
    bit [9:0] addr;
    bit [3:0] iwe;
    bit [2:0] ore;
    bit [31:0] idata, wdata;
  } vec_t;

  function automatic int ni(int u); return u == 3 ? 4 : u == 1 ? 1 : 2; endfunction
  function automatic int no(int u); return u == 2 ? 3 : 1; endfunction
  function automatic int lt(int u); return u == 1 ? 3 : u == 3 ? 2 : 1; endfunction
  function automatic logic [31:0] pat(logic [9:0] a); return {12'hA5C, 10'h000, a}; endfunction
  function automatic logic [31:0] opat(int u, int t); return {8'(8'hD0 + u), 8'h00, 16'(t)}; endfunction

  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ed [NU];
  int sp [NU];
  vec_t ex [NU][NC];
  vec_t ob [NU][NC];
  logic [9:0] hist [NU][NC];

  logic [NU-1:0] rst_n, start, abort, eu_done;
  logic [NU-1:0][39:0] src;
  logic [NU-1:0][29:0] dst;
  logic [NU-1:0][31:0] rdata, odata, id_v, wd_v;
  logic [NU-1:0] re_v, we_v, es_v, dn_v, bz_v;
  logic [NU-1:0][9:0] addr_v;
  logic [NU-1:0][3:0] iwe_v;
  logic [NU-1:0][2:0] ore_v;

  for (genvar g = 0; g < NU; g++) begin : gu
    localparam int N = g == 3 ? 4 : g == 1 ? 1 : 2;
    localparam int O = g == 2 ? 3 : 1;
    localparam int L = g == 1 ? 3 : g == 3 ? 2 : 1;
    logic [N-1:0] input_we;
    logic [O-1:0] output_re;
    rmio_seq_ctrl #(.INPUT_NUM(N), .OUTPUT_NUM(O), .DATA_W(32), .ADDR_W(10), .RD_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n[g]), .start(start[g]), .abort(abort[g]),
      .src_addr(src[g][N*10-1:0]), .dst_addr(dst[g][O*10-1:0]),
      .busy(bz_v[g]), .done(dn_v[g]), .ram_addr(addr_v[g]), .ram_re(re_v[g]), .ram_we(we_v[g]),
      .ram_rdata(rdata[g]), .ram_wdata(wd_v[g]), .input_data(id_v[g]), .input_we(input_we),
      .output_data(odata[g]), .output_re(output_re), .eu_start(es_v[g]), .eu_done(eu_done[g]));
    assign iwe_v[g] = 4'(input_we);
    assign ore_v[g] = 3'(output_re);
  end

  // expected cycle schedule of one operation launched with start sampled at cycle c; nothing after cycle ab
  task automatic plan(input int u, input int c, input int ab, output int es);
    int rd, we, e, dn;
    we = c;
    for (int t = c + 1; t < c + 80 && t < NC; t++) ex[u][t] = '0;
    for (int k = 0; k < ni(u); k++) begin
`ifdef RMIO_SEQ_PIPE_RD_EN
      rd = c + 1 + k;
`else
      rd = c + 1 + k * (lt(u) + 1);
`endif
      we = rd + lt(u);
      if (rd <= ab) begin
        ex[u][rd].re = 1;
        ex[u][rd].addr = src[u][k*10 +: 10];
      end
      if (we <= ab) begin
        ex[u][we].iwe = 4'(1 << k);
        ex[u][we].idata = pat(src[u][k*10 +: 10]);
      end
    end
    es = we + 1;
    e = es + 3;
    ed[u] = e;
    dn = e + 1 + no(u);
    if (es <= ab) ex[u][es].es = 1;
    for (int k = 0; k < no(u); k++)
      if (e + 1 + k <= ab) begin
        ex[u][e+1+k].we = 1;
        ex[u][e+1+k].ore = 3'(1 << k);
        ex[u][e+1+k].addr = dst[u][k*10 +: 10];
        ex[u][e+1+k].wdata = opat(u, e + 1 + k);
      end
    if (dn <= ab) ex[u][dn].dn = 1;
    for (int t = c + 1; t <= dn && t <= ab; t++) ex[u][t].bz = 1;
  endtask

  task automatic arm(input int u, input logic [39:0] s, input logic [29:0] d, output int es);
    src[u] = s;
    dst[u] = d;
    start[u] = 1;
    plan(u, cyc, BIG, es);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic lit(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  function automatic int ndone(int u, int a, int b);
    int n = 0;
    for (int t = a; t <= b; t++) n += int'(ob[u][t].dn);
    return n;
  endfunction

  // RAM returns the address pattern RD_LAT cycles after each read; EU result and eu_done follow the schedule
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int u = 0; u < NU; u++) begin
      rdata[u] = cyc >= lt(u) && cyc - lt(u) < NC ? pat(hist[u][cyc-lt(u)]) : '0;
      odata[u] = opat(u, cyc);
      eu_done[u] = cyc == ed[u] || cyc == sp[u];
    end
  end

  // per-cycle comparison of every DUT output against the schedule model
  always @(negedge clk) begin : cmp
    vec_t o;
    for (int u = 0; u < NU; u++) begin
      o = '0;
      o.re = re_v[u];
      o.we = we_v[u];
      o.es = es_v[u];
      o.dn = dn_v[u];
      o.bz = bz_v[u];
      o.addr = addr_v[u];
      o.iwe = iwe_v[u];
      o.ore = ore_v[u];
      o.idata = iwe_v[u] != 0 ? id_v[u] : '0;
      o.wdata = we_v[u] ? wd_v[u] : '0;
      if (cyc < NC) begin
        ob[u][cyc] = o;
        hist[u][cyc] = re_v[u] ? addr_v[u] : '0;
        checks++;
        if (o != ex[u][cyc]) begin
          failures++;
          $display("FAIL cycle u%0d cyc=%0d got=%h want=%h", u, cyc, o, ex[u][cyc]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c1, c2, c3, c4, c5, c6, es, es3, r;
    rst_n = '0;
    start = '0;
    abort = '0;
    src = '0;
    dst = '0;
    for (int u = 0; u < NU; u++) begin
      ed[u] = -1;
      sp[u] = -1;
    end
    repeat (3) @(negedge clk);
    rst_n = '1;
    wait_cyc(8);
    c1 = cyc;
    arm(0, 40'({10'h020, 10'h010}), 30'h030, es);
    arm(1, 40'h044, 30'h055, es);
    arm(2, 40'({10'h012, 10'h011}), 30'({10'h7, 10'h6, 10'h5}), es);
    arm(3, 40'({10'h104, 10'h103, 10'h102, 10'h101}), 30'h200, es);
    @(negedge clk);
    start = '0;
    wait_cyc(c1 + 25);
    c2 = cyc;
    sp[0] = c2 + 2;
    arm(0, 40'({10'h3FF, 10'h200}), 30'h1AB, es);
    @(negedge clk);
    start = '0;
    wait_cyc(es + 1);
    start[0] = 1;
    src[0] = 40'h0BEEF;
    @(negedge clk);
    start = '0;
    wait_cyc(c2 + 20);
    c3 = cyc;
    arm(2, 40'({10'h0AA, 10'h0BB}), 30'({10'h3, 10'h2, 10'h1}), es3);
    plan(2, c3, es3 + 1, es3);
    @(negedge clk);
    start = '0;
    wait_cyc(es3 + 1);
    abort[2] = 1;
    @(negedge clk);
    abort = '0;
    wait_cyc(c3 + 20);
    c4 = cyc;
    arm(2, 40'({10'h0C2, 10'h0C1}), 30'({10'h9, 10'h8, 10'h7}), es);
    @(negedge clk);
    start = '0;
    wait_cyc(c4 + 20);
    c5 = cyc;
    arm(1, 40'h066, 30'h077, es);
    r = es + 4;
    plan(1, c5, r - 1, es);
    @(negedge clk);
    start = '0;
    wait_cyc(r - 1);
    @(posedge clk);
    #2;
    rst_n[1] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1;
    wait_cyc(r + 4);
    c6 = cyc;
    arm(1, 40'h0E1, 30'h0E2, es);
    @(negedge clk);
    start = '0;
    wait_cyc(c6 + 20);
`ifndef RMIO_SEQ_PIPE_RD_EN
    lit("u0_rd0_addr", ob[0][c1+1].re ? int'(ob[0][c1+1].addr) : -1, 'h010);
    lit("u0_rd1_addr", ob[0][c1+3].re ? int'(ob[0][c1+3].addr) : -1, 'h020);
    lit("u0_iwe_c2", int'(ob[0][c1+2].iwe), 1);
    lit("u0_iwe_c3", int'(ob[0][c1+3].iwe), 0);
    lit("u0_iwe_c4", int'(ob[0][c1+4].iwe), 2);
    lit("u0_idata_c4", int'(ob[0][c1+4].idata), int'(32'hA5C00020));
    lit("u0_eu_start_c5", int'(ob[0][c1+5].es), 1);
    lit("u0_wr_addr", ob[0][c1+9].we ? int'(ob[0][c1+9].addr) : -1, 'h030);
    lit("u0_done_c10", int'(ob[0][c1+10].dn), 1);
    lit("u1_rd_c1", int'(ob[1][c1+1].re), 1);
    lit("u1_quiet_c2_c3", int'(ob[1][c1+2].re) + int'(ob[1][c1+2].iwe) + int'(ob[1][c1+3].re) + int'(ob[1][c1+3].iwe), 0);
    lit("u1_iwe_c4", int'(ob[1][c1+4].iwe), 1);
    lit("u2_ore_0", int'(ob[2][c1+9].ore), 1);
    lit("u2_ore_1", int'(ob[2][c1+10].ore), 2);
    lit("u2_ore_2", int'(ob[2][c1+11].ore), 4);
    lit("u2_wr_addr2", int'(ob[2][c1+11].addr), 7);
    lit("u2_done", int'(ob[2][c1+12].dn), 1);
`else
    for (int k = 0; k < 4; k++) begin
      lit("u3_pipe_re", int'(ob[3][c1+1+k].re), 1);
      lit("u3_pipe_iwe", int'(ob[3][c1+3+k].iwe), 1 << k);
    end
    lit("u3_pipe_re_end", int'(ob[3][c1+5].re), 0);
    lit("u3_pipe_eu_start", int'(ob[3][c1+7].es), 1);
    lit("u3_pipe_no_early_es", int'(ob[3][c1+6].es), 0);
`endif
    lit("u0_one_done_ignored_start", ndone(0, c2, c2 + 19), 1);
    lit("u2_abort_no_done", ndone(2, c3, c3 + 19), 0);
    lit("u2_abort_idle", int'(ob[2][es3+2].bz) + int'(ob[2][es3+2].we), 0);
    lit("u2_fresh_done", ndone(2, c4, c4 + 19), 1);
    lit("u1_reset_idle", int'(ob[1][r].bz) + int'(ob[1][r].we) + int'(ob[1][r].ore), 0);
    lit("u1_reset_no_done", ndone(1, c5, c6), 0);
    lit("u1_fresh_done", ndone(1, c6, c6 + 19), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rmio_seq_ctrl.md
Name: rmio_seq_ctrl

Overview:
- Sequencer that drives the RF-side of the RF-RAM ↔ execution-unit link for one EU operation.
- On `start` it:
  - reads INPUT_NUM operand rows from RF RAM and strobes each into the EU;
  - pulses `eu_start`, then waits for `eu_done`;
  - drains OUTPUT_NUM result rows from the EU back into RF RAM.
- Sits between the instruction decoder (start/addresses), the RF RAM port and the EU.

Parameters:
- INPUT_NUM, 2, number of operand rows loaded per operation (≥1)
- OUTPUT_NUM, 1, number of result rows drained per operation (≥1)
- DATA_W, 1408, row width in bits (176 bytes)
- ADDR_W, 10, RF RAM address width
- RD_LAT, 1, RF RAM read latency in cycles (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  launch operation; sampled only in IDLE
- abort  in  1  cancel current operation
- src_addr  in  INPUT_NUM*ADDR_W  operand row addresses, slice i = operand i; latched at start
- dst_addr  in  OUTPUT_NUM*ADDR_W  result row addresses, slice j = result j; latched at start
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on completion
- ram_addr  out  ADDR_W  RF RAM address
- ram_re  out  1  RF RAM read enable
- ram_we  out  1  RF RAM write enable
- ram_rdata  in  DATA_W  RF RAM read data, valid RD_LAT cycles after ram_re
- ram_wdata  out  DATA_W  RF RAM write data
- input_data  out  DATA_W  operand row to EU
- input_we  out  INPUT_NUM  one-hot operand strobe to EU
- output_data  in  DATA_W  result row from EU
- output_re  out  OUTPUT_NUM  one-hot result strobe to EU
- eu_start  out  1  one-cycle EU launch pulse
- eu_done  in  1  EU results ready

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; counters and latched addresses cleared.
  - busy, done, ram_re, ram_we, input_we, output_re, eu_start all 0; ram_addr 0.
  - Effective immediately, including mid-operation; no further strobes after release until a new start.
- Output timing:
  - All strobes and ram_addr are decoded from registered state only, with no combinational input→strobe path.
  - Datapath passthroughs: input_data = ram_rdata; ram_wdata = output_data (combinational).
- States: IDLE, RD_ISSUE, RD_WAIT, LOAD, EXEC, EXEC_WAIT, WR, DONE.
- IDLE:
  - start=1 latches src_addr/dst_addr, sets i=0 → RD_ISSUE.
  - start=0 stays in IDLE.
- RD_ISSUE: ram_re=1, ram_addr=src[i]. → RD_WAIT if RD_LAT>1, else → LOAD.
- RD_WAIT: counts RD_LAT-1 cycles → LOAD.
- LOAD:
  - input_we[i]=1 for exactly this cycle; ram_rdata valid in this cycle.
  - i<INPUT_NUM-1: i++ → RD_ISSUE. Otherwise → EXEC.
- EXEC: eu_start=1 for one cycle → EXEC_WAIT.
- EXEC_WAIT:
  - Waits for eu_done=1, then sets j=0 → WR.
  - eu_done is ignored in every other state.
  - There is no timeout; use abort to leave.
- WR:
  - output_re[j]=1, ram_we=1, ram_addr=dst[j], all in the same cycle; the EU presents output_data in that cycle.
  - j<OUTPUT_NUM-1: j++ and stay in WR. Otherwise → DONE.
- DONE: done=1 for one cycle → IDLE. busy is 1 in DONE and 0 the cycle after.
- start while busy: ignored; not queued.
- abort (any non-IDLE state): → IDLE next edge.
  - No done pulse.
  - The current cycle's strobes still complete.
  - abort has priority over every other transition.
- start and abort both high in IDLE: start wins; abort is ignored in IDLE.
- Timing, non-pipelined:
  - Input phase = INPUT_NUM*(RD_LAT+1) cycles.
  - Defaults, start sampled at cycle C:
    - ram_re at C+1 and C+3
    - input_we[0] at C+2, input_we[1] at C+4
    - eu_start at C+5
  - After eu_done is sampled at cycle E: WR at E+1, done at E+2.

Optional Feature:
- Macro: RMIO_SEQ_PIPE_RD_EN.
- Defined: operand reads are pipelined.
  - RD_ISSUE issues one read per cycle for i=0..INPUT_NUM-1 (ram_re held high).
  - input_we[k] asserts exactly RD_LAT cycles after the read of operand k.
  - eu_start follows the cycle after the last input_we.
  - Input phase = INPUT_NUM+RD_LAT cycles.
  - abort during the phase suppresses all not-yet-asserted input_we.
- Undefined: sequential issue/wait/load as specified above.

Test Plan:
- Defaults, start with src={0x010,0x020}, dst=0x030; ram_rdata returns the address pattern; eu_done 3 cycles after eu_start → required response:
  - ram_re at C+1 (addr 0x010) and C+3 (addr 0x020);
  - input_we=01 at C+2, 10 at C+4; eu_start at C+5;
  - ram_we at addr 0x030 with wdata=output_data one cycle after eu_done; then done.
- RD_LAT=3, INPUT_NUM=1 → input_we[0] exactly 3 cycles after ram_re; no other strobe in between.
- OUTPUT_NUM=3, dst={5,6,7} → output_re=001,010,100 on consecutive cycles; ram_we with addr 5,6,7; done the next cycle.
- start pulsed during EXEC_WAIT and eu_done pulsed during the input phase → both ignored; exactly one done, after the real eu_done.
- abort in EXEC_WAIT, and separately rst_n low in WR → IDLE with all strobes 0 next cycle (reset: immediately); no done; a fresh start afterwards runs normally.
- RMIO_SEQ_PIPE_RD_EN defined, INPUT_NUM=4, RD_LAT=2 → ram_re high at C+1..C+4; input_we[k] at C+3+k; eu_start at C+7.
